// File: rtl/slot_diff_log.sv
// slot_diff_log: per-slot frame change monitor for the 32-slot multiplexed pipeline.
// Aligns to the slot sequence, primes a 32-entry frame store, then reports every
// per-slot value change against the previous frame through a small event FIFO.
// Optional feature: define SLOT_DIFF_MASK_EN to add the per-position `mask` input.
module slot_diff_log #(
    parameter int unsigned width = 10,
    parameter int unsigned stg   = 0,
    parameter int unsigned depth = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] mixed,
    input  logic [4:0]       cnt,
    input  logic             arm,
`ifdef SLOT_DIFF_MASK_EN
    input  logic [31:0]      mask,
`endif
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [4:0]       ev_pos,
    output logic [width-1:0] ev_old,
    output logic [width-1:0] ev_new,
    output logic             overflow,
    output logic [15:0]      frames,
    output logic             running
);

    // pos = (cnt + 33 - stg) mod 32, folded into a constant 5-bit offset
    localparam logic [4:0]  PosOff = 5'((33 - (stg % 32)) % 32);
    localparam int unsigned Aw     = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned EvW    = 5 + 2 * width;
    localparam logic [Aw:0]   CntOne  = (Aw + 1)'(1);
    localparam logic [Aw:0]   CntFull = (Aw + 1)'(depth);
    localparam logic [Aw-1:0] PtrOne  = Aw'(1);

    typedef enum logic [1:0] {StIdle, StSync, StPrime, StRun} state_e;

    state_e             state_q, state_d;
    logic               arm_q;
    logic [width-1:0]   store_q [32];
    logic [EvW-1:0]     mem_q [depth];
    logic [Aw-1:0]      wptr_q, rptr_q;
    logic [Aw:0]        count_q;
    logic               overflow_q;
    logic [15:0]        frames_q;

    logic [4:0]         pos;
    logic               pos_en;
    logic               arm_rise;
    logic               differs;
    logic               store_wr;
    logic               push;
    logic               frame_done;
    logic               pop;
    logic               full;
    logic               do_write;
    logic               drop;

    assign pos      = cnt + PosOff;
    assign arm_rise = arm & ~arm_q;
    assign differs  = (store_q[pos] != mixed);

`ifdef SLOT_DIFF_MASK_EN
    assign pos_en = mask[pos];
`else
    assign pos_en = 1'b1;
`endif

    assign ev_valid = (count_q != '0);
    assign pop      = ev_valid & ev_ready;
    assign full     = (count_q == CntFull);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
    assign do_write = push & (~full | pop);
    assign drop     = push & full & ~pop;

    assign {ev_pos, ev_old, ev_new} = mem_q[rptr_q];
    assign overflow = overflow_q;
    assign frames   = frames_q;
    assign running  = (state_q == StRun);

    // Next-state and per-cycle actions; dropping arm aborts everything this cycle
    always_comb begin
        state_d    = state_q;
        store_wr   = 1'b0;
        push       = 1'b0;
        frame_done = 1'b0;
        if (!arm) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  state_d = StSync;
                StSync:  if (pos == 5'd31) state_d = StPrime;
                StPrime: begin
                    store_wr = 1'b1;
                    if (pos == 5'd31) state_d = StRun;
                end
                StRun: begin
                    store_wr   = differs;
                    push       = differs & pos_en;
                    frame_done = (pos == 5'd31);
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM state and arm history for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm;
        end
    end

    // Frame store: one value per slot position; masked or dropped changes still land here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) store_q[i] <= '0;
        end else if (store_wr) begin
            store_q[pos] <= mixed;
        end
    end

    // Event storage, reset so the head outputs read zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(depth); i++) mem_q[i] <= '0;
        end else if (do_write && !arm_rise) begin
            mem_q[wptr_q] <= {pos, store_q[pos], mixed};
        end
    end

    // FIFO pointers, sticky overflow and frame counter; a new arm session clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            frames_q   <= '0;
        end else if (arm_rise) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            frames_q   <= '0;
        end else begin
            if (do_write) wptr_q <= wptr_q + PtrOne;
            if (pop)      rptr_q <= rptr_q + PtrOne;
            if (do_write && !pop)      count_q <= count_q + CntOne;
            else if (!do_write && pop) count_q <= count_q - CntOne;
            if (drop) overflow_q <= 1'b1;
            if (frame_done && frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
        end
    end

endmodule

// File: doc/slot_diff_log.md
# slot_diff_log

Downstream monitor for the 32-slot time-multiplexed operator pipeline, fed by the same mixed signal and slot counter as the per-slot separator. Aligns to the slot sequence, stores one full frame of per-slot values, and emits a change event whenever a slot's value differs from the previous frame. Events go into a small FIFO and are drained through a valid/ready port by the bench.

## Interface
- `width`, default 10: bit width of the sampled signal.
- `stg`, default 0: pipeline stage of the sampled signal. Slot position `pos = (cnt + 33 - stg) mod 32`.
- `depth`, default 8: number of FIFO event entries. Power of two, minimum 2.
- `clk`  in  1: the only clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `mixed`  in  width: time-multiplexed signal, one slot per cycle.
- `cnt`  in  5: slot counter driving the pipeline.
- `arm`  in  1: level-sensitive enable for monitoring.
- `mask`  in  32: per-position event enable, bit n = position n. Present only with `SLOT_DIFF_MASK_EN`.
- `ev_valid`  out  1: FIFO head is valid.
- `ev_ready`  in  1: consumer accepts the head.
- `ev_pos`  out  5: slot position of the event.
- `ev_old`  out  width: value stored from the previous frame.
- `ev_new`  out  width: newly sampled value.
- `overflow`  out  1: sticky flag, set when at least one event was dropped.
- `frames`  out  16: count of fully compared frames, saturating at 16'hFFFF.
- `running`  out  1: high in RUN state.

## Operation
- Position-to-slot map: pos 0–7 = ch0–7 slot1, 8–15 = ch0–7 slot3, 16–23 = ch0–7 slot2, 24–31 = ch0–7 slot4.
- Frame store: 32 × width registers, indexed by pos.
- FSM states:
  - IDLE: waits for `arm`=1, then goes to SYNC.
  - SYNC: waits for a cycle with pos==31, then goes to PRIME.
  - PRIME: writes `mixed` into store[pos] for positions 0..31 and generates no events. On the write of pos 31 it goes to RUN.
  - RUN: each cycle compares `mixed` with store[pos]. If they differ, it pushes {pos, store[pos], mixed}, then writes store[pos] ← mixed. At pos 31 it increments `frames` (saturating).
- `arm`=0 in any state returns the FSM to IDLE on the next edge. The FIFO, `overflow` and `frames` are kept.
- A rising edge of `arm` (0→1) clears `overflow`, `frames` and the FIFO.
- Push while the FIFO is full and no pop in the same cycle: the event is dropped and `overflow` is set. The store is still updated.
- Push and pop in the same cycle are always legal, including when the FIFO is full. Occupancy is unchanged.
- Pop happens when `ev_valid & ev_ready`.
- The `ev_*` outputs hold stable while `ev_valid`=1 and `ev_ready`=0.

## Timing
- Reset values: `ev_valid`=0, `ev_pos`=0, `ev_old`=0, `ev_new`=0, `overflow`=0, `frames`=0, `running`=0. FSM is in IDLE, FIFO is empty, store is all zeros.
- `pos` is combinational from `cnt`. Sampling happens on the same edge that the sample is presented.
- Latency: a difference sampled at edge N into an empty FIFO gives `ev_valid`=1 after edge N, visible in cycle N+1.
- `running` is registered and rises on the edge that writes pos 31 in PRIME.
- From `arm` rising to first possible event: 1 cycle IDLE→SYNC, up to 32 cycles in SYNC, 32 cycles in PRIME.
- `rst_n` assertion mid-frame clears everything immediately, without waiting for a clock edge. Operation restarts from IDLE after release.

## Configuration
- `SLOT_DIFF_MASK_EN` defined:
  - `mask` port exists.
  - A difference at pos n is pushed only if mask[n]=1. A masked difference still updates the store.
- `SLOT_DIFF_MASK_EN` undefined:
  - No `mask` port.
  - All 32 positions generate events.

## Test plan
- Constant `mixed`=10'h155, `cnt` free-running, `arm`=1 for 200 cycles → `ev_valid` stays 0, `frames` is 2 after 138 cycles (1 + up to 32 + 32 + 64 + margin), `running`=1.
- Baseline 0, with pos 5 set to 10'h3FF once in RUN, `stg`=0 → exactly one event {pos 5, old 0, new 3FF}. The following frame gives {5, 3FF, 0}.
- `ev_ready`=0, with all 32 slots toggling in RUN and `depth`=8 → 8 events held in order (pos 0..7), `overflow`=1. Raising `ev_ready` drains exactly those 8.
- `stg`=3, change injected when `cnt`=2 → event reports pos 0.
- `arm` dropped at pos 12 of RUN, then re-armed → FSM goes through SYNC and PRIME again, `overflow`/`frames`/FIFO are cleared, and no event appears before re-priming completes.
- `rst_n` pulsed low asynchronously mid-frame with 3 events queued → all outputs are at their reset values before the next clock edge. With `SLOT_DIFF_MASK_EN` and mask=32'h1 → only pos 0 changes are reported.
